// File: rtl/mem_port_arbiter.sv
// Arbitrates one asynchronous-read/synchronous-write memory between fetch (I) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, D over I.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_i_resp_data;
    logic [31:0]      r_d_resp_data;

    logic w_idle;
    logic w_busy;
    logic w_resp;
    logic w_pick_d;
    logic w_grant_d;
    logic w_grant_i;

    // Outputs are gated by reset so a store caught mid-flight never reaches the memory.
    assign w_idle = (r_state == S_IDLE) && !reset;
    assign w_busy = (r_state == S_BUSY) && !reset;
    assign w_resp = (r_state == S_RESP) && !reset;

`ifdef MEM_ARB_RR_EN
    logic r_last_owner;

    assign w_pick_d = d_req_valid && (!i_req_valid || !r_last_owner);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= 1'b0;
        end else if (w_grant_d || w_grant_i) begin
            r_last_owner <= w_grant_d;
        end
    end
`else
    assign w_pick_d = d_req_valid;
`endif

    assign w_grant_d = w_idle && w_pick_d;
    assign w_grant_i = w_idle && i_req_valid && !w_pick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_i_resp_data <= '0;
            r_d_resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_owner <= 1'b1;
                        r_write <= d_req_write;
                        r_addr  <= d_req_addr;
                        r_wdata <= d_req_write ? d_req_wdata : 32'd0;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_BUSY;
                    end else if (w_grant_i) begin
                        r_owner <= 1'b0;
                        r_write <= 1'b0;
                        r_addr  <= i_req_addr;
                        r_wdata <= 32'd0;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (r_owner) begin
                            r_d_resp_data <= r_write ? 32'd0 : mem_dout;
                        end else begin
                            r_i_resp_data <= mem_dout;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_req_ready  = w_grant_i;
    assign d_req_ready  = w_grant_d;
    assign i_resp_valid = w_resp && !r_owner;
    assign d_resp_valid = w_resp && r_owner;
    assign i_resp_data  = reset ? 32'd0 : r_i_resp_data;
    assign d_resp_data  = reset ? 32'd0 : r_d_resp_data;
    assign mem_addr     = w_busy ? r_addr : 32'd0;
    assign mem_din      = w_busy ? r_wdata : 32'd0;
    assign mem_read     = w_busy && !r_write;
    assign mem_write    = w_busy && r_write && (r_cnt == '0);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance for most scenarios and a
// LATENCY=1 instance for back-to-back fetches, each with its own small memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        iReqValid, iReqReady, iRespValid;
    logic [31:0] iReqAddr, iRespData;
    logic        dReqValid, dReqWrite, dReqReady, dRespValid;
    logic [31:0] dReqAddr, dReqWdata, dRespData;
    logic [31:0] memAddr, memDin, memDout;
    logic        memRead, memWrite;

    logic        i1Valid, i1Ready, i1RespValid;
    logic [31:0] i1Addr, i1RespData;
    logic        d1Ready, d1RespValid;
    logic [31:0] d1RespData;
    logic [31:0] mem1Addr, mem1Din, mem1Dout;
    logic        mem1Read, mem1Write;

    logic [31:0] mem2 [0:255];
    logic [31:0] mem1 [0:255];
    logic        preWe;
    logic [7:0]  preIdx;
    logic [31:0] preData;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.LATENCY(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(iReqValid), .i_req_addr(iReqAddr), .i_req_ready(iReqReady),
        .i_resp_valid(iRespValid), .i_resp_data(iRespData),
        .d_req_valid(dReqValid), .d_req_write(dReqWrite), .d_req_addr(dReqAddr),
        .d_req_wdata(dReqWdata), .d_req_ready(dReqReady),
        .d_resp_valid(dRespValid), .d_resp_data(dRespData),
        .mem_addr(memAddr), .mem_din(memDin), .mem_read(memRead),
        .mem_write(memWrite), .mem_dout(memDout)
    );

    mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset),
        .i_req_valid(i1Valid), .i_req_addr(i1Addr), .i_req_ready(i1Ready),
        .i_resp_valid(i1RespValid), .i_resp_data(i1RespData),
        .d_req_valid(1'b0), .d_req_write(1'b0), .d_req_addr(32'd0),
        .d_req_wdata(32'd0), .d_req_ready(d1Ready),
        .d_resp_valid(d1RespValid), .d_resp_data(d1RespData),
        .mem_addr(mem1Addr), .mem_din(mem1Din), .mem_read(mem1Read),
        .mem_write(mem1Write), .mem_dout(mem1Dout)
    );

    // Word-indexed memories: asynchronous read, synchronous write, plus a bench preload port.
    always @(posedge clk) begin
        if (preWe) begin
            mem2[preIdx] <= preData;
            mem1[preIdx] <= preData;
        end else if (memWrite) begin
            mem2[memAddr[9:2]] <= memDin;
        end
    end
    assign memDout  = mem2[memAddr[9:2]];
    assign mem1Dout = mem1[mem1Addr[9:2]];

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task preload(input logic [7:0] idx, input logic [31:0] data);
        preWe = 1'b1;
        preIdx = idx;
        preData = data;
        @(posedge clk); #1;
        preWe = 1'b0;
    endtask

    // Drives one request on the LATENCY=2 instance and checks every cycle through RESP.
    // After acceptance the request inputs are scrambled to prove they are not resampled.
    task applyStimulus(input logic isD, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] expData, input string tag);
        iReqValid = !isD;
        iReqAddr  = addr;
        dReqValid = isD;
        dReqWrite = wr;
        dReqAddr  = addr;
        dReqWdata = wdata;
        @(negedge clk);
        checkOutput({tag, ".iRdy"}, 32'(iReqReady), 32'(!isD));
        checkOutput({tag, ".dRdy"}, 32'(dReqReady), 32'(isD));
        checkOutput({tag, ".idleResp"}, 32'({iRespValid, dRespValid}), 32'd0);
        checkOutput({tag, ".idleRead"}, 32'({memRead, memWrite}), 32'd0);
        @(posedge clk); #1;
        iReqValid = 1'b0;
        dReqValid = 1'b0;
        iReqAddr  = addr ^ 32'h60;
        dReqAddr  = addr ^ 32'h60;
        dReqWdata = ~wdata;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checkOutput({tag, ".busyAddr"}, memAddr, addr);
            checkOutput({tag, ".busyDin"}, memDin, wr ? wdata : 32'd0);
            checkOutput({tag, ".busyRead"}, 32'(memRead), 32'(!wr));
            checkOutput({tag, ".busyWrite"}, 32'(memWrite), 32'(wr && k == 2));
            checkOutput({tag, ".busyRdy"}, 32'({iReqReady, dReqReady}), 32'd0);
            checkOutput({tag, ".busyResp"}, 32'({iRespValid, dRespValid}), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput({tag, ".iRespV"}, 32'(iRespValid), 32'(!isD));
        checkOutput({tag, ".dRespV"}, 32'(dRespValid), 32'(isD));
        checkOutput({tag, ".respData"}, isD ? dRespData : iRespData, expData);
        checkOutput({tag, ".respMem"}, 32'({memRead, memWrite}) | memAddr, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    logic        firstD;
    logic [31:0] exp1 [0:2];

    initial begin
        exp1[0] = 32'h1111_0000;
        exp1[1] = 32'h2222_0001;
        exp1[2] = 32'h3333_0002;
        reset = 1'b1;
        preWe = 1'b0; preIdx = '0; preData = '0;
        iReqValid = 1'b0; iReqAddr = '0;
        dReqValid = 1'b0; dReqWrite = 1'b0; dReqAddr = '0; dReqWdata = '0;
        i1Valid = 1'b0; i1Addr = '0;
        @(posedge clk); #1;
        preload(8'd4, 32'h0062_8233);
        preload(8'd8, 32'hA5A5_0008);
        preload(8'd16, 32'h0000_0040);
        preload(8'd64, 32'h0000_0000);
        preload(8'd128, 32'h0000_0000);
        preload(8'd0, exp1[0]);
        preload(8'd1, exp1[1]);
        preload(8'd2, exp1[2]);

        @(negedge clk);
        checkOutput("rst.rdy", 32'({iReqReady, dReqReady, i1Ready, d1Ready}), 32'd0);
        checkOutput("rst.resp", 32'({iRespValid, dRespValid, i1RespValid, d1RespValid}), 32'd0);
        checkOutput("rst.mem", memAddr | memDin | 32'({memRead, memWrite}), 32'd0);
        checkOutput("rst.data", iRespData | dRespData | i1RespData | d1RespData, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle.mem", memAddr | 32'({memRead, memWrite}), 32'd0);
        @(posedge clk); #1;

        applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 32'h0062_8233, "fetch");
        applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'd0, "store");
        applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, "load");
        applyStimulus(1'b1, 1'b0, 32'h20, 32'd0, 32'hA5A5_0008, "addrChg");

        // Simultaneous requests; the previous grant went to D.
`ifdef MEM_ARB_RR_EN
        firstD = 1'b0;
`else
        firstD = 1'b1;
`endif
        iReqValid = 1'b1; iReqAddr = 32'h10;
        dReqValid = 1'b1; dReqWrite = 1'b0; dReqAddr = 32'h100;
        @(negedge clk);
        checkOutput("both.iRdy", 32'(iReqReady), 32'(!firstD));
        checkOutput("both.dRdy", 32'(dReqReady), 32'(firstD));
        @(posedge clk); #1;
        if (firstD) dReqValid = 1'b0; else iReqValid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("both.waitRdy", 32'({iReqReady, dReqReady}), 32'd0);
            if (k == 3) begin
                checkOutput("both.firstResp", 32'({iRespValid, dRespValid}), firstD ? 32'd1 : 32'd2);
                checkOutput("both.firstData", firstD ? dRespData : iRespData,
                            firstD ? 32'hDEAD_BEEF : 32'h0062_8233);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("both.secondRdy", 32'({iReqReady, dReqReady}), firstD ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        iReqValid = 1'b0; dReqValid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checkOutput("both.secondResp", 32'({iRespValid, dRespValid}), firstD ? 32'd2 : 32'd1);
                checkOutput("both.secondData", firstD ? iRespData : dRespData,
                            firstD ? 32'h0062_8233 : 32'hDEAD_BEEF);
            end
            @(posedge clk); #1;
        end

        // Reset lands in the final BUSY cycle of a store.
        dReqValid = 1'b1; dReqWrite = 1'b1; dReqAddr = 32'h200; dReqWdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rstSt.dRdy", 32'(dReqReady), 32'd1);
        @(posedge clk); #1;
        dReqValid = 1'b0; dReqWrite = 1'b0;
        @(negedge clk);
        checkOutput("rstSt.busy1Write", 32'(memWrite), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstSt.memCtl", 32'({memRead, memWrite}), 32'd0);
        checkOutput("rstSt.memBus", memAddr | memDin, 32'd0);
        checkOutput("rstSt.resp", 32'({iRespValid, dRespValid, iReqReady, dReqReady}), 32'd0);
        checkOutput("rstSt.data", iRespData | dRespData, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 32'h0062_8233, "postRst");
        checkOutput("rstSt.memUntouched", mem2[128], 32'd0);

        // Back-to-back fetches on the LATENCY=1 instance with valid held high.
        i1Valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            i1Addr = 32'(n * 4);
            @(negedge clk);
            checkOutput("l1.rdy", 32'(i1Ready), 32'd1);
            @(posedge clk); #1;
            i1Addr = 32'((n + 1) * 4);
            @(negedge clk);
            checkOutput("l1.busyRdy", 32'(i1Ready), 32'd0);
            checkOutput("l1.busyRead", 32'({mem1Read, mem1Write}), 32'd2);
            checkOutput("l1.busyAddr", mem1Addr | mem1Din, 32'(n * 4));
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("l1.respV", 32'({i1RespValid, d1RespValid, i1Ready, d1Ready}), 32'd8);
            checkOutput("l1.respData", i1RespData, exp1[n]);
            checkOutput("l1.dData", d1RespData, 32'd0);
            @(posedge clk); #1;
        end
        i1Valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
